mdu_seq: RTL and testbench
==========================

MDU_SEQ -- requirements
Module: mdu_seq

Interface
REQ-001 Parameter W, default 32, operand width; latency and all widths below scale with W.
REQ-002 clk  input  1  rising-edge clock; the block has only this one clock.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  operation request, sampled at the rising edge of clk.
REQ-005 op  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 a  input  W  multiplicand or dividend, sampled with start.
REQ-007 b  input  W  multiplier or divisor, sampled with start.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  one-cycle pulse when hi, lo and div_by_zero are valid.
REQ-010 hi  output  W  product upper half, or remainder.
REQ-011 lo  output  W  product lower half, or quotient.
REQ-012 div_by_zero  output  1  set with done when a divide had b==0; cleared on the next accepted start.

Function
REQ-013 The block SHALL use exactly one W-bit add/subtract datapath (A, B, C0 -> s, Co; C0=1 selects subtract) shared by multiply and divide, one operation per cycle.
REQ-014 The FSM SHALL have the states IDLE, PREP, ITER, FIXUP and DONE, with transitions IDLE->PREP on an accepted start, PREP->ITER, ITER->ITER for W cycles, ITER->FIXUP, FIXUP->DONE and DONE->IDLE.
REQ-015 start SHALL be accepted only in IDLE; start in any other state SHALL be ignored, and a and b SHALL NOT be resampled.
REQ-016 busy SHALL be 1 in PREP, ITER, FIXUP and DONE, and 0 in IDLE.
REQ-017 With start accepted at edge N, done SHALL be 1 exactly in the cycle after edge N+W+2 (latency W+3 cycles); a new start is accepted at the earliest in the cycle after done.
REQ-018 In PREP, signed ops SHALL convert the operands to magnitudes, record the result sign (a xor b) and the remainder sign (a), and clear the W-bit iteration counter; unsigned ops SHALL pass the operands unchanged.
REQ-019 Multiply SHALL be radix-2 shift-add: each ITER cycle adds the multiplicand to the upper accumulator when the LSB is 1, then shifts the 2W-bit accumulator right by 1, capturing Co.
REQ-020 Divide SHALL be restoring: each ITER cycle shifts the remainder:quotient left by 1, trial-subtracts the divisor, and keeps the difference and sets the quotient bit when no borrow occurs.
REQ-021 In FIXUP, signed multiply SHALL negate the 2W-bit product when the sign is 1; signed divide SHALL negate the quotient by result sign and the remainder by dividend sign (truncation toward zero).
REQ-022 Results SHALL wrap modulo 2^W: DIV of 0x80000000 by 0xFFFFFFFF gives lo=0x80000000, hi=0.
REQ-023 A divide with b==0 SHALL keep full latency and return hi=a, lo=all ones and div_by_zero=1.
REQ-024 hi and lo SHALL update only on entry to DONE and hold until the next DONE.
REQ-025 done SHALL never be asserted in two consecutive cycles.

Reset
REQ-026 While rst=1 at an edge, the block SHALL enter IDLE with busy=0, done=0, hi=0, lo=0, div_by_zero=0 and the counter cleared.
REQ-027 rst asserted mid-operation SHALL abort the operation with no done pulse; start sampled in the same cycle as rst SHALL be ignored.

Configuration
REQ-028 Macro MDU_DIV_EN defined: DIVU and DIV SHALL be supported as specified above.
REQ-029 Macro MDU_DIV_EN undefined: no divide logic SHALL be synthesised; a start with op[1]=1 SHALL go IDLE->DONE, with done in the cycle after the accepting edge, hi=lo=0 and div_by_zero=0; multiply SHALL be unchanged.

Verification
REQ-030 The bench SHALL cover MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> after 35 cycles done, hi=0xFFFFFFFE, lo=0x00000001.
REQ-031 The bench SHALL cover MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21).
REQ-032 The bench SHALL cover DIV a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); and DIVU a=100, b=7 -> lo=14, hi=2.
REQ-033 The bench SHALL cover DIVU a=0x1234, b=0 -> hi=0x1234, lo=0xFFFFFFFF, div_by_zero=1 with done at latency 35.
REQ-034 The bench SHALL cover start pulsed again at cycle 5 with new operands -> ignored, and the first result is unchanged.
REQ-035 The bench SHALL cover rst at cycle 10 of a MULT -> busy=0 and no done for 40 cycles; then a new MULTU 3x4 -> lo=12.

Source files
------------

// File: rtl/mdu_seq.sv
// mdu_seq: sequential multiply/divide unit.
//   MULTU/MULT: radix-2 shift-add, 2W-bit product returned as {hi, lo}.
//   DIVU/DIV  : restoring division, quotient in lo, remainder in hi,
//               signed results truncate toward zero.
// All iteration arithmetic runs through one shared W-bit add/subtract datapath.
// Latency from the accepting edge to done is W+3 cycles.
// Configuration macro: MDU_DIV_EN. When it is defined, the divide ops are built.
// When it is undefined, no divide logic exists. A divide request then returns
// zeros one cycle after it is accepted.
module mdu_seq #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo,
    output logic         div_by_zero
);

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        ITER,
        FIXUP,
        DONE
    } state_t;

    localparam logic [W-1:0] ITER_LAST = W'(W - 1);

    state_t       state;
    logic [W-1:0] cnt;        // iteration counter
    logic [W-1:0] p_hi;       // product upper half / partial remainder
    logic [W-1:0] p_lo;       // multiplier then product lower half / dividend then quotient
    logic [W-1:0] opnd;       // multiplicand or divisor
    logic         op_signed;  // latched op[0]
    logic         res_sign;   // sign of product or quotient
`ifdef MDU_DIV_EN
    logic         op_div;     // latched op[1]
    logic         rem_sign;   // sign of remainder (follows the dividend)
    logic         dbz_r;      // divisor was zero
    logic [W-1:0] rem_shift;  // partial remainder shifted left by one
`endif

    // shared add/subtract datapath
    logic [W-1:0] add_a;
    logic [W-1:0] add_b;
    logic         add_sub;
    logic [W-1:0] add_s;
    logic         add_co;

    // final results presented in FIXUP
    logic [W-1:0] fix_hi;
    logic [W-1:0] fix_lo;

    // Two's-complement magnitude when the value is treated as signed.
    function automatic logic [W-1:0] magnitude(input logic [W-1:0] x, input logic is_signed);
        return (is_signed && x[W-1]) ? (~x + W'(1)) : x;
    endfunction

`ifdef MDU_DIV_EN
    assign rem_shift = {p_hi[W-2:0], p_lo[W-1]};
`endif

    // Select the operands of the shared adder for the current iteration.
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        add_a   = p_hi;
        add_b   = '0;
        add_sub = 1'b0;
`ifdef MDU_DIV_EN
        if (op_div) begin
            add_a   = rem_shift;
            add_b   = opnd;
            add_sub = 1'b1;
        end else
`endif
        if (p_lo[0]) begin
            add_b = opnd;
        end
    end

    // Subtraction is A + ~B + 1. For subtraction, Co=1 means no borrow.
    assign {add_co, add_s} = {1'b0, add_a} + {1'b0, add_b ^ {W{add_sub}}} + {{W{1'b0}}, add_sub};

    // Apply sign correction to the raw iteration results.
    always_comb begin
        fix_hi = p_hi;
        fix_lo = p_lo;
`ifdef MDU_DIV_EN
        if (op_div) begin
            if (res_sign) begin
                fix_lo = ~p_lo + W'(1);
            end
            if (rem_sign) begin
                fix_hi = ~p_hi + W'(1);
            end
            // Restoring division by zero already leaves the remainder equal to a.
            // The quotient is forced to all ones regardless of sign.
            if (dbz_r) begin
                fix_lo = '1;
            end
        end else
`endif
        if (res_sign) begin
            {fix_hi, fix_lo} = ~{p_hi, p_lo} + (2 * W)'(1);
        end
    end

    // Control FSM and datapath registers. The outputs are registered.
    // NOTE: state is updated with non-blocking assignments, so every branch sees the values from before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: datapath registers are reset along with the control state, so the outputs are never X after reset.
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
            cnt         <= '0;
            p_hi        <= '0;
            p_lo        <= '0;
            opnd        <= '0;
            op_signed   <= 1'b0;
            res_sign    <= 1'b0;
`ifdef MDU_DIV_EN
            op_div      <= 1'b0;
            rem_sign    <= 1'b0;
            dbz_r       <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        div_by_zero <= 1'b0;
                        op_signed   <= op[0];
                        p_lo        <= a;
                        opnd        <= b;
                        busy        <= 1'b1;
`ifdef MDU_DIV_EN
                        op_div      <= op[1];
                        state       <= PREP;
`else
                        if (op[1]) begin
                            // divide is not built: answer with zeros at once
                            hi    <= '0;
                            lo    <= '0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= PREP;
                        end
`endif
                    end
                end

                PREP: begin
                    p_hi     <= '0;
                    cnt      <= '0;
                    p_lo     <= magnitude(p_lo, op_signed);
                    opnd     <= magnitude(opnd, op_signed);
                    res_sign <= op_signed & (p_lo[W-1] ^ opnd[W-1]);
`ifdef MDU_DIV_EN
                    rem_sign <= op_signed & p_lo[W-1];
                    dbz_r    <= op_div & (opnd == '0);
`endif
                    state    <= ITER;
                end

                ITER: begin
                    cnt <= cnt + W'(1);
`ifdef MDU_DIV_EN
                    if (op_div) begin
                        // keep the difference when the shifted-out bit or no-borrow says it fits
                        if (p_hi[W-1] || add_co) begin
                            p_hi <= add_s;
                            p_lo <= {p_lo[W-2:0], 1'b1};
                        end else begin
                            p_hi <= rem_shift;
                            p_lo <= {p_lo[W-2:0], 1'b0};
                        end
                    end else
`endif
                    begin
                        p_hi <= {add_co, add_s[W-1:1]};
                        p_lo <= {add_s[0], p_lo[W-1:1]};
                    end
                    if (cnt == ITER_LAST) begin
                        state <= FIXUP;
                    end
                end

                FIXUP: begin
                    hi    <= fix_hi;
                    lo    <= fix_lo;
`ifdef MDU_DIV_EN
                    div_by_zero <= dbz_r;
`endif
                    done  <= 1'b1;
                    state <= DONE;
                end

                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: self-checking bench for mdu_seq (W = 32).
// The expected results come from 64-bit integer arithmetic on the operands.
// The expected latency follows the same MDU_DIV_EN setting as the design.
module tb_mdu_seq;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div_by_zero;

    int errors = 0;
    int checks = 0;

    mdu_seq #(.W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: ops 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
    function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] eh, output logic [31:0] el, output logic ez);
        logic [63:0] p;
        longint      sx;
        longint      sy;
        longint      q;
        longint      r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ez = 1'b0;
        eh = '0;
        el = '0;
        case (o)
            2'b00: begin
                p = {32'b0, x} * {32'b0, y};
                {eh, el} = p;
            end
            2'b01: begin
                p = 64'(sx * sy);
                {eh, el} = p;
            end
            default: begin
`ifdef MDU_DIV_EN
                if (y == 32'd0) begin
                    eh = x;
                    el = 32'hFFFF_FFFF;
                    ez = 1'b1;
                end else if (o == 2'b10) begin
                    el = x / y;
                    eh = x % y;
                end else begin
                    q  = sx / sy;
                    r  = sx % sy;
                    el = q[31:0];
                    eh = r[31:0];
                end
`endif
            end
        endcase
    endfunction

    // Expected number of edges after the accepting edge before done is seen.
    function automatic int exp_lat(input logic [1:0] o);
`ifdef MDU_DIV_EN
        return W + 2;
`else
        return o[1] ? 0 : W + 2;
`endif
    endfunction

    // Operands are mostly random. Some are corner values: 0, -1, min, 1.
    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h0000_0001;
            4:       return 32'($urandom_range(0, 255));
            default: return 32'($urandom);
        endcase
    endfunction

    // Drive one operation from IDLE. Collect the result and the edges counted to done.
    // Entered and left at 1 time unit after a rising edge, with the block idle.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] rh, output logic [31:0] rl, output logic rz,
                          output int lat);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rh = hi;
        rl = lo;
        rz = div_by_zero;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        op    = 2'b00;
        a     = 32'd5;
        b     = 32'd6;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, hi, lo, div_by_zero} !== '0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b hi=%h lo=%h dbz=%b, want all zero",
                     busy, done, hi, lo, div_by_zero);
        end
        rst   = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_start_ignored: got busy=%b, want 0", busy);
        end
    endtask

    task automatic test_directed();
        logic [1:0]  ops [10] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b10, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00};
        logic [31:0] as  [10] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd100, 32'h1234,
                                  32'h8000_0000, 32'hFFFF_FFF9, 32'h8000_0000, 32'h8000_0000, 32'd0};
        logic [31:0] bs  [10] = '{32'hFFFF_FFFF, 32'd7, 32'd2, 32'd7, 32'd0,
                                  32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 32'h8000_0001, 32'h1234_5678};
        logic [31:0] rh, rl, eh, el;
        logic        rz, ez;
        int          lat;
        for (int i = 0; i < 10; i++) begin
            run_op(ops[i], as[i], bs[i], rh, rl, rz, lat);
            model(ops[i], as[i], bs[i], eh, el, ez);
            checks++;
            if ({rh, rl, rz} !== {eh, el, ez}) begin
                errors++;
                $display("FAIL directed_%0d result op=%b a=%h b=%h: got hi=%h lo=%h dbz=%b, want hi=%h lo=%h dbz=%b",
                         i, ops[i], as[i], bs[i], rh, rl, rz, eh, el, ez);
            end
            checks++;
            if (lat !== exp_lat(ops[i])) begin
                errors++;
                $display("FAIL directed_%0d latency: got %0d, want %0d", i, lat, exp_lat(ops[i]));
            end
        end
        // the cycle after DONE is IDLE: busy low, done already gone
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL after_done_idle: got busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_random();
        logic [1:0]  o;
        logic [31:0] x, y, rh, rl, eh, el;
        logic        rz, ez;
        int          lat;
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            x = pick_operand();
            y = pick_operand();
            run_op(o, x, y, rh, rl, rz, lat);
            model(o, x, y, eh, el, ez);
            checks++;
            if ({rh, rl, rz, lat} !== {eh, el, ez, exp_lat(o)}) begin
                errors++;
                $display("FAIL random_%0d op=%b a=%h b=%h: got hi=%h lo=%h dbz=%b lat=%0d, want hi=%h lo=%h dbz=%b lat=%0d",
                         i, o, x, y, rh, rl, rz, lat, eh, el, ez, exp_lat(o));
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [31:0] eh, el;
        logic        ez;
        int          lat;
        op    = 2'b01;
        a     = 32'hFFFF_FF85;
        b     = 32'd1000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        op    = 2'b00;
        a     = 32'h1357_9BDF;
        b     = 32'h2468_ACE0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 5;
        while (done !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        model(2'b01, 32'hFFFF_FF85, 32'd1000, eh, el, ez);
        checks++;
        if ({hi, lo, div_by_zero, lat} !== {eh, el, ez, W + 2}) begin
            errors++;
            $display("FAIL ignore_start: got hi=%h lo=%h dbz=%b lat=%0d, want hi=%h lo=%h dbz=%b lat=%0d",
                     hi, lo, div_by_zero, lat, eh, el, ez, W + 2);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL ignore_start_idle: got busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] rh, rl;
        logic        rz;
        int          lat;
        int          seen_done;
        int          seen_busy;
        op    = 2'b01;
        a     = 32'hFFFF_FFFD;
        b     = 32'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst   = 1'b1;
        start = 1'b1;
        a     = 32'd9;
        b     = 32'd9;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        checks++;
        if ({busy, done, hi, lo, div_by_zero} !== '0) begin
            errors++;
            $display("FAIL abort_reset_state: got busy=%b done=%b hi=%h lo=%h dbz=%b, want all zero",
                     busy, done, hi, lo, div_by_zero);
        end
        seen_done = 0;
        seen_busy = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) seen_done++;
            if (busy !== 1'b0) seen_busy++;
        end
        checks++;
        if (seen_done != 0 || seen_busy != 0) begin
            errors++;
            $display("FAIL abort_quiet: got done cycles=%0d busy cycles=%0d, want 0 0", seen_done, seen_busy);
        end
        run_op(2'b00, 32'd3, 32'd4, rh, rl, rz, lat);
        checks++;
        if ({rh, rl, rz, lat} !== {32'd0, 32'd12, 1'b0, W + 2}) begin
            errors++;
            $display("FAIL abort_then_multu: got hi=%h lo=%h dbz=%b lat=%0d, want hi=0 lo=c dbz=0 lat=%0d",
                     rh, rl, rz, lat, W + 2);
        end
    endtask

    task automatic test_back_to_back();
        int          done_at [3];
        int          n_done;
        int          doubles;
        int          idle_wait;
        logic [31:0] eh, el;
        logic        ez;
        logic        prev_done;
        model(2'b00, 32'hDEAD_BEEF, 32'h0BAD_F00D, eh, el, ez);
        op        = 2'b00;
        a         = 32'hDEAD_BEEF;
        b         = 32'h0BAD_F00D;
        start     = 1'b1;
        n_done    = 0;
        doubles   = 0;
        prev_done = 1'b0;
        for (int e = 0; e < 3 * (W + 4) + 4 && n_done < 3; e++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                if (prev_done) doubles++;
                done_at[n_done] = e;
                n_done++;
                checks++;
                if ({hi, lo, div_by_zero} !== {eh, el, ez}) begin
                    errors++;
                    $display("FAIL b2b_result_%0d: got hi=%h lo=%h dbz=%b, want hi=%h lo=%h dbz=%b",
                             n_done, hi, lo, div_by_zero, eh, el, ez);
                end
            end
            prev_done = done;
        end
        start = 1'b0;
        checks++;
        if (n_done != 3 || doubles != 0 || done_at[0] != W + 2 ||
            done_at[1] - done_at[0] != W + 4 || done_at[2] - done_at[1] != W + 4) begin
            errors++;
            $display("FAIL b2b_timing: got dones=%0d doubles=%0d first=%0d gaps=%0d,%0d, want 3 0 %0d %0d,%0d",
                     n_done, doubles, done_at[0], done_at[1] - done_at[0], done_at[2] - done_at[1],
                     W + 2, W + 4, W + 4);
        end
        idle_wait = 0;
        while (busy !== 1'b0 && idle_wait < 100) begin
            @(posedge clk);
            #1;
            idle_wait++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: got busy=%b, want 0", busy);
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
